// File: rtl/drisc_bus_pkg.sv
// Shared types and constants for the drisc external memory bus arbiter.
package drisc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef logic master_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // One master's transaction as it is latched onto the memory bus.
    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [1:0]  size;
    } bus_req_t;

endpackage

// File: rtl/bus_grant_select.sv
// Picks which master is granted next; ARBITER_ROUND_ROBIN_EN selects round-robin
// between contending masters, otherwise master 0 has fixed priority.
module bus_grant_select
    import drisc_bus_pkg::*;
(
    input  logic       m0_req,
    input  logic       m1_req,
    input  master_id_t last_grant,
    output logic       grant_valid,
    output master_id_t grant_id
);

`ifdef ARBITER_ROUND_ROBIN_EN
    // On contention the master that did not win last time takes the bus.
    always_comb begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = m1_req;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_id    = m1_req & ~m0_req;
    end
`endif

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter for the external memory bus: IDLE/ACCESS/DONE transaction FSM
// with timeout; build with ARBITER_ROUND_ROBIN_EN for round-robin grants.
module memory_bus_arbiter
    import drisc_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_size,
    output logic        m0_ready,
    output logic        m0_error,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_size,
    output logic        m1_ready,
    output logic        m1_error,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arb_state_t  state_q, state_d;
    logic [7:0]  count_q, count_d;
    master_id_t  grant_q, grant_d;
    master_id_t  last_grant_q, last_grant_d;
    bus_req_t    cur_q, cur_d;
    bus_req_t    m0_bus, m1_bus, sel_req;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  error_q, error_d;
    logic [31:0] rdata_q [2];
    logic [31:0] rdata_d [2];
    logic        grant_valid;
    master_id_t  grant_id;

    bus_grant_select u_grant_select (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign m0_bus  = '{write: m0_write, address: m0_address, wdata: m0_wdata, size: m0_size};
    assign m1_bus  = '{write: m1_write, address: m1_address, wdata: m1_wdata, size: m1_size};
    assign sel_req = grant_id ? m1_bus : m0_bus;

    // Strobes, ready and error are recomputed every cycle so they fall as soon as
    // the state they belong to is left; everything else holds unless updated.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ready_d      = 2'b00;
        error_d      = 2'b00;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    grant_d      = grant_id;
                    last_grant_d = grant_id;
                    cur_d        = sel_req;
                    count_d      = 8'd0;
                    mem_read_d   = ~sel_req.write;
                    mem_write_d  = sel_req.write;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // An acknowledge on the final wait cycle still counts as success.
                if (mem_ready) begin
                    if (!cur_q.write) begin
                        rdata_d[grant_q] = mem_rdata;
                    end
                    ready_d[grant_q] = 1'b1;
                    state_d          = DONE;
                end else if (count_q == TIMEOUT_CNT) begin
                    rdata_d[grant_q] = 32'd0;
                    ready_d[grant_q] = 1'b1;
                    error_d[grant_q] = 1'b1;
                    state_d          = DONE;
                end else begin
                    count_d     = count_q + 8'd1;
                    mem_read_d  = ~cur_q.write;
                    mem_write_d = cur_q.write;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to master 1 so master 0 wins the first contested grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 8'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cur_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ready_q      <= 2'b00;
            error_q      <= 2'b00;
            rdata_q[0]   <= 32'd0;
            rdata_q[1]   <= 32'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign mem_address = cur_q.address;
    assign mem_wdata   = cur_q.wdata;
    assign mem_size    = cur_q.size;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign m0_ready    = ready_q[0];
    assign m1_ready    = ready_q[1];
    assign m0_error    = error_q[0];
    assign m1_error    = error_q[1];
    assign m0_rdata    = rdata_q[0];
    assign m1_rdata    = rdata_q[1];

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Randomized self-checking bench for memory_bus_arbiter against a transaction-level model.
module tb_memory_bus_arbiter;
    import drisc_bus_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata;
    logic [1:0]  m0_size, m1_size;
    logic        m0_ready, m0_error, m1_ready, m1_error;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        mem_read, mem_write, mem_ready;

    int          tests_run = 0;
    int          tests_failed = 0;
    bit          model_last;
    logic [31:0] model_rdata [2];
    int          grant_log [$];

    memory_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_wdata(m0_wdata),
        .m0_size(m0_size), .m0_ready(m0_ready), .m0_error(m0_error), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_wdata(m1_wdata),
        .m1_size(m1_size), .m1_ready(m1_ready), .m1_error(m1_error), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setRequest(input bit idx, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] sz);
        if (idx) begin
            m1_req = 1'b1; m1_write = wr; m1_address = addr; m1_wdata = wd; m1_size = sz;
        end else begin
            m0_req = 1'b1; m0_write = wr; m0_address = addr; m0_wdata = wd; m0_size = sz;
        end
    endtask

    task automatic randomRequest(input bit idx);
        setRequest(idx, 1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 2)));
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
        checkOutput({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
        checkOutput({tag, "_m0_error"}, 32'(m0_error), 32'd0);
        checkOutput({tag, "_m1_error"}, 32'(m1_error), 32'd0);
        checkOutput({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
    endtask

    // Starts in an IDLE cycle with requests already driven; the memory acknowledges
    // after wait_cycles ACCESS cycles (beyond TIMEOUT means never). Ends in the
    // IDLE cycle that follows the ready pulse.
    task automatic applyStimulus(input int wait_cycles, input logic [31:0] rd_val);
        bit          g, ok, exp_wr;
        logic [31:0] exp_addr, exp_wdata;
        logic [1:0]  exp_size;
        int          access_len;

        if (m0_req && m1_req) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            g = !model_last;
`else
            g = 1'b0;
`endif
        end else begin
            g = m1_req;
        end
        model_last = g;
        grant_log.push_back(int'(g));
        exp_wr    = g ? m1_write   : m0_write;
        exp_addr  = g ? m1_address : m0_address;
        exp_wdata = g ? m1_wdata   : m0_wdata;
        exp_size  = g ? m1_size    : m0_size;
        ok         = (wait_cycles <= TIMEOUT);
        access_len = ok ? wait_cycles + 1 : TIMEOUT + 1;
        mem_ready  = 1'b0;

        for (int a = 0; a < access_len; a++) begin
            tick();
            mem_ready = (a == wait_cycles);
            mem_rdata = (a == wait_cycles) ? rd_val : $urandom;
            checkOutput("acc_mem_read", 32'(mem_read), 32'(!exp_wr));
            checkOutput("acc_mem_write", 32'(mem_write), 32'(exp_wr));
            checkOutput("acc_mem_address", mem_address, exp_addr);
            checkOutput("acc_mem_wdata", mem_wdata, exp_wdata);
            checkOutput("acc_mem_size", 32'(mem_size), 32'(exp_size));
            checkOutput("acc_ready", 32'({m1_ready, m0_ready}), 32'd0);
            if (g) begin
                m1_address = $urandom; m1_wdata = $urandom; m1_size = 2'($urandom);
            end else begin
                m0_address = $urandom; m0_wdata = $urandom; m0_size = 2'($urandom);
            end
        end

        tick();
        mem_ready = 1'b0;
        if (!ok)          model_rdata[g] = 32'd0;
        else if (!exp_wr) model_rdata[g] = rd_val;
        checkOutput("done_m0_ready", 32'(m0_ready), 32'(!g));
        checkOutput("done_m1_ready", 32'(m1_ready), 32'(g));
        checkOutput("done_m0_error", 32'(m0_error), 32'(!g && !ok));
        checkOutput("done_m1_error", 32'(m1_error), 32'(g && !ok));
        checkOutput("done_m0_rdata", m0_rdata, model_rdata[0]);
        checkOutput("done_m1_rdata", m1_rdata, model_rdata[1]);
        checkOutput("done_strobes", 32'({mem_read, mem_write}), 32'd0);
        if (g) m1_req = 1'b0; else m0_req = 1'b0;

        tick();
        checkQuiet("idle");
        checkOutput("idle_m0_rdata", m0_rdata, model_rdata[0]);
        checkOutput("idle_m1_rdata", m1_rdata, model_rdata[1]);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        m0_req = 1'b0; m0_write = 1'b0; m0_address = '0; m0_wdata = '0; m0_size = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_address = '0; m1_wdata = '0; m1_size = '0;
        model_last = 1'b1;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        tick();
        tick();
        checkQuiet("reset");
        checkOutput("reset_mem_address", mem_address, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_m0_rdata", m0_rdata, 32'd0);
        checkOutput("reset_m1_rdata", m1_rdata, 32'd0);
        reset = 1'b0;

        // Zero-wait load, delayed store, timeout, acknowledge on the last allowed cycle.
        setRequest(1'b0, 1'b0, 32'h100, 32'h0, SIZE_WORD);
        applyStimulus(0, 32'hDEADBEEF);
        setRequest(1'b1, 1'b1, 32'h200, 32'h12345678, SIZE_HALF);
        applyStimulus(3, 32'hCAFEF00D);
        setRequest(1'b0, 1'b0, 32'h300, 32'h0, SIZE_BYTE);
        applyStimulus(99, 32'h55AA55AA);
        setRequest(1'b1, 1'b0, 32'h400, 32'h0, SIZE_WORD);
        applyStimulus(TIMEOUT, 32'h0BADF00D);

        // Both masters requesting continuously.
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            if (!m0_req) randomRequest(1'b0);
            if (!m1_req) randomRequest(1'b1);
            applyStimulus($urandom_range(0, 2), $urandom);
        end
`ifdef ARBITER_ROUND_ROBIN_EN
        checkOutput("contention_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} & 4'hF), 32'h5);
`else
        checkOutput("contention_order", 32'(grant_log[0] + grant_log[1] + grant_log[2] + grant_log[3]), 32'd0);
`endif
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        checkQuiet("drop");

        // Random traffic; a pending loser keeps its request and fields.
        for (int i = 0; i < 40; i++) begin
            if (!m0_req && $urandom_range(0, 1) == 1) randomRequest(1'b0);
            if (!m1_req && $urandom_range(0, 1) == 1) randomRequest(1'b1);
            if (!m0_req && !m1_req) begin
                tick();
                checkQuiet("rand_idle");
            end else begin
                applyStimulus($urandom_range(0, TIMEOUT + 2), $urandom);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // Reset during ACCESS of an m1 load.
        setRequest(1'b1, 1'b0, 32'h500, 32'h0, SIZE_WORD);
        mem_ready = 1'b0;
        tick();
        checkOutput("rst_mid_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m1_req = 1'b0;
        model_last = 1'b1;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        checkQuiet("rst_mid");
        checkOutput("rst_mid_address", mem_address, 32'd0);
        checkOutput("rst_mid_m1_rdata", m1_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkQuiet("rst_after");
        end
        setRequest(1'b1, 1'b0, 32'h600, 32'h0, SIZE_WORD);
        applyStimulus(1, 32'h13579BDF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the single external memory bus between two masters: master 0 is the drisc core's pad interface, master 1 is a debug/DMA port. A three-state FSM grants one master per transaction, latches its request, drives the memory strobes until the memory acknowledges or a timeout fires, and returns a one-cycle ready pulse with read data. The block sits between the core's bus pads and the board-level memory.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles in ACCESS before abort. Legal range is 1..255.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  request; held high until the matching ready pulse
- m0_write / m1_write  in  1  1 = store, 0 = load
- m0_address / m1_address  in  32  byte address
- m0_wdata / m1_wdata  in  32  store data
- m0_size / m1_size  in  2  access size: 00 byte, 01 half, 10 word
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_error / m1_error  out  1  high together with ready when the transaction timed out
- m0_rdata / m1_rdata  out  32  load data; valid only while ready is high, holds its value otherwise
- mem_address  out  32  latched address
- mem_wdata  out  32  latched store data
- mem_size  out  2  latched size
- mem_read / mem_write  out  1  strobes; high only in ACCESS
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory acknowledge, sampled in ACCESS

## Operation
- **States:** IDLE, ACCESS, DONE. All outputs are registered.
- **IDLE:**
  - If any request is high, pick a grantee.
  - Latch the grantee's address, wdata, size and write into the mem_* registers.
  - Clear the wait counter and go to ACCESS.
- **Grant without ARBITER_ROUND_ROBIN_EN:** master 0 always wins when both request.
- **ACCESS:**
  - mem_read = !write and mem_write = write for the latched transaction.
  - When mem_ready is sampled high: capture mem_rdata into the grantee's rdata (loads only; stores leave rdata unchanged), then go to DONE with error = 0.
  - Otherwise, if the counter equals TIMEOUT: set grantee rdata = 0, go to DONE with error = 1.
  - Otherwise increment the counter.
- **DONE:**
  - Grantee's ready is high, plus error if set.
  - Strobes are low and requests are ignored, giving the master one cycle to drop req.
  - Always returns to IDLE.
- **Exclusivity:** at most one of m0_ready and m1_ready is ever high. The ungranted master's req stays pending with no side effects.
- **Input changes:** changes on master inputs after the latch in IDLE are ignored until the next grant.
- **Counter:** 8 bits, never wraps. ACCESS lasts at most TIMEOUT+1 cycles.

## Timing
- **Reset values:** state IDLE, every ready/error/strobe 0, all mem_* and rdata registers 0, last-grant register = 1 (so master 0 wins the first contested grant).
- **Reset mid-transaction:** reset is asserted at edge N. After edge N the strobes are 0, the state is IDLE, and no ready pulse is produced.
- **Zero-wait access:**
  - req seen in IDLE at cycle 0.
  - ACCESS in cycle 1 with mem_ready high.
  - ready in cycle 2.
  - IDLE in cycle 3.
- **Latency and throughput:** req-to-ready is 2 + W cycles for W wait cycles. Maximum throughput is one transaction per 3 cycles.
- **Timeout:** the error pulse appears TIMEOUT+2 cycles after the req cycle.
- **Simultaneous events:** mem_ready high in the same cycle the counter reaches TIMEOUT counts as success, not error.

## Configuration
- **ARBITER_ROUND_ROBIN_EN defined:**
  - A last-grant register updates on every grant.
  - On a contested IDLE cycle, the master that was not granted last wins.
  - Uncontested requests are granted directly and also update last-grant.
- **Not defined:** the last-grant register is absent and master 0 has fixed priority. Master 1 can starve under continuous master 0 traffic; this is accepted for single-core builds.

## Structure
- **Package drisc_bus_pkg** holds:
  - arb_state_t enum (IDLE, ACCESS, DONE)
  - master_id_t (1 bit)
  - size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - a request struct bundling write, address, wdata and size
- **Sub-module bus_grant_select:** combinational. Takes both req bits and last-grant and returns grant_valid and grant_id. Contains the ARBITER_ROUND_ROBIN_EN conditional so the FSM is identical in both builds.

## Test plan
- **Single load:** m0 loads word 0x100, mem_ready high immediately, mem_rdata = 0xDEADBEEF. Required: mem_read high only in cycle 1, m0_ready in cycle 2 with m0_rdata = 0xDEADBEEF, m0_error = 0.
- **Wait states:** m1 stores 0x12345678 at 0x200, size 01, with mem_ready delayed 3 cycles. Required: mem_write held 4 cycles, mem_size = 01 throughout, m1_ready 5 cycles after req.
- **Timeout:** TIMEOUT = 4, mem_ready never asserted. Required: m0_ready and m0_error together 6 cycles after req, m0_rdata = 0.
- **Contention:** both masters request continuously for 4 transactions. Required with macro: grants alternate 0,1,0,1. Required without macro: 0,0,0,0 and m1 never ready.
- **Reset mid-access:** assert reset during ACCESS of an m1 load. Required: strobes 0 and state IDLE after that edge, no ready pulse. A subsequent m1 request completes normally.
